// File: rtl/rx_cp_remove_if.sv
// CYC/STB/WE/ACK sample stream: master drives dat/we/stb/cyc, slave returns ack.
interface rx_cp_remove_if #(
    parameter int DAT_W = 32
);
    logic [DAT_W-1:0] dat;
    logic             we;
    logic             stb;
    logic             cyc;
    logic             ack;

    modport master (output dat, output we, output stb, output cyc, input ack);
    modport slave  (input dat, input we, input stb, input cyc, output ack);
endinterface

// File: rtl/rx_cp_remove.sv
// Strips the cyclic prefix from each OFDM symbol and forwards the FFT_LEN body samples; one clock latency.
// Prefix samples are always accepted; body samples stall on a held output that downstream has not acked.
module rx_cp_remove #(
    parameter int DAT_W   = 32,
    parameter int CP_LEN  = 32,
    parameter int FFT_LEN = 256
) (
    input  logic             clk,
    input  logic             rst,
    rx_cp_remove_if.slave    in_if,
    rx_cp_remove_if.master   out_if,
    output logic             sym_done
);
    localparam int SYM_LEN = CP_LEN + FFT_LEN;
    localparam int CNT_W   = $clog2(SYM_LEN);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_BODY = cnt_t'(CP_LEN);
    localparam cnt_t CNT_LAST = cnt_t'(SYM_LEN - 1);

    cnt_t             cnt_q, cnt_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic             stb_q, stb_d;
    logic             last_q, last_d;
    logic             cyc_q, cyc_d;
    logic             sd_q, sd_d;

    logic drop;
    logic req;
    logic ack;
    logic load;
    logic out_xfer;

    always_comb begin
        drop     = (cnt_q < CNT_BODY);
        req      = in_if.cyc & in_if.stb & in_if.we;
        ack      = ~rst & req & (drop | ~stb_q | out_if.ack);
        load     = ack & ~drop;
        out_xfer = stb_q & out_if.ack;

        // Dropping cyc_i mid-symbol abandons it; the next symbol starts at prefix position 0.
        cnt_d = cnt_q;
        if (!in_if.cyc) begin
            cnt_d = '0;
        end else if (ack) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + cnt_t'(1);
        end

        dat_d  = dat_q;
        stb_d  = stb_q;
        last_d = last_q;
        if (load) begin
            dat_d  = in_if.dat;
            stb_d  = 1'b1;
            last_d = (cnt_q == CNT_LAST);
        end else if (out_xfer) begin
            stb_d = 1'b0;
        end

        // An aborted symbol has no last sample: close cyc_o once nothing is held and the count is back in the prefix.
        cyc_d = cyc_q;
        if (load) begin
            cyc_d = 1'b1;
        end else if (out_xfer && last_q) begin
            cyc_d = 1'b0;
        end else if (!stb_d && (cnt_d < CNT_BODY)) begin
            cyc_d = 1'b0;
        end

        sd_d = out_xfer & last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dat_q  <= '0;
            stb_q  <= 1'b0;
            last_q <= 1'b0;
            cyc_q  <= 1'b0;
            sd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dat_q  <= dat_d;
            stb_q  <= stb_d;
            last_q <= last_d;
            cyc_q  <= cyc_d;
            sd_q   <= sd_d;
        end
    end

    assign in_if.ack  = ack;
    assign out_if.dat = dat_q;
    assign out_if.stb = stb_q;
    assign out_if.we  = stb_q;
    assign out_if.cyc = cyc_q;
    assign sym_done   = sd_q;

endmodule

// File: tb/tb_rx_cp_remove.sv
// Directed stimulus for rx_cp_remove with a queue scoreboard checked by an independent output monitor.
module tb_rx_cp_remove;
    localparam int DW  = 32;
    localparam int CP  = 32;
    localparam int FFT = 256;
    localparam int SYM = CP + FFT;

    logic clk = 1'b0;
    logic rst;
    logic sym_done;

    always #5 clk = ~clk;

    rx_cp_remove_if #(.DAT_W(DW)) in_if ();
    rx_cp_remove_if #(.DAT_W(DW)) out_if ();

    rx_cp_remove #(.DAT_W(DW), .CP_LEN(CP), .FFT_LEN(FFT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_if),
        .out_if   (out_if),
        .sym_done (sym_done)
    );

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int pos      = 0;
    int ack_mode = 0;
    int pops     = 0;
    int cyc_hi   = 0;
    int sd_cnt   = 0;
    int first_pop = -1;
    int last_pop  = -1;
    int lat_cyc   = -1;
    bit lat_arm   = 0;
    bit lat_done  = 0;
    bit exp_sd    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    initial out_if.ack = 1'b0;
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       out_if.ack = 1'b1;
            1:       out_if.ack = ~out_if.ack;
            default: out_if.ack = 1'b0;
        endcase
    end

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        bit   nx;
        nx = 0;
        if (!rst) begin
            chk("sym_done", sym_done, exp_sd);
            chk("we_o_eq_stb_o", out_if.we, out_if.stb);
            if (out_if.stb && out_if.ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("dat_o", out_if.dat, e.d);
                    nx = e.last;
                end
                pops++;
                if (first_pop < 0) first_pop = cycle;
                last_pop = cycle;
            end
            if (out_if.cyc) cyc_hi++;
            if (sym_done) sd_cnt++;
            if (lat_arm && !lat_done && out_if.stb) begin
                chk("first_stb_latency", cycle, lat_cyc);
                lat_done = 1;
            end
        end
        exp_sd = nx;
    end

    task automatic send(input int v);
        int n;
        bit acc;
        n = 0;
        in_if.dat = v;
        in_if.cyc = 1'b1;
        in_if.stb = 1'b1;
        in_if.we  = 1'b1;
        do begin
            @(negedge clk);
            acc = in_if.ack;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        chk("in_accept", acc, 1);
        if (acc) begin
            if (pos >= CP) begin
                exp_t e;
                e.d    = v;
                e.last = (pos == SYM - 1);
                q.push_back(e);
            end
            if (lat_arm && pos == CP) lat_cyc = cycle;
            pos = (pos + 1) % SYM;
        end
    endtask

    task automatic send_range(input int a, input int b);
        for (int v = a; v <= b; v++) send(v);
    endtask

    task automatic idle(input int n);
        in_if.cyc = 1'b0;
        in_if.stb = 1'b0;
        in_if.we  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        pops = 0; cyc_hi = 0; sd_cnt = 0; first_pop = -1; last_pop = -1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_if.dat = 32'hDEAD_BEEF;
        in_if.cyc = 1'b1;
        in_if.stb = 1'b1;
        in_if.we  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_o", in_if.ack, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        @(negedge clk);
        chk("rst_stb_o", out_if.stb, 0);
        chk("rst_cyc_o", out_if.cyc, 0);
        chk("rst_dat_o", out_if.dat, 0);
        chk("rst_sym_done", sym_done, 0);
        chk("rst_cnt", dut.cnt_q, 0);

        // we_i=0 is never accepted, even in the always-accepting prefix phase
        @(posedge clk); #1;
        in_if.cyc = 1'b1; in_if.stb = 1'b1; in_if.we = 1'b0; in_if.dat = 7;
        repeat (3) begin
            @(negedge clk);
            chk("we0_ack_o", in_if.ack, 0);
        end
        idle(1);

        // One symbol, full throughput, latency check
        clear_stats();
        lat_arm = 1;
        send_range(1, SYM);
        drain();
        lat_arm = 0;
        chk("t1_out_count", pops, FFT);
        chk("t1_cyc_o_cycles", cyc_hi, FFT);
        chk("t1_back_to_back", last_pop - first_pop, FFT - 1);
        chk("t1_sym_done", sd_cnt, 1);

        // Three back-to-back symbols
        clear_stats();
        send_range(1, 3 * SYM);
        drain();
        chk("t2_out_count", pops, 3 * FFT);
        chk("t2_sym_done", sd_cnt, 3);
        chk("t2_cnt_end", dut.cnt_q, 0);

        // Downstream ack toggling every clock
        clear_stats();
        ack_mode = 1;
        send_range(1, SYM);
        drain();
        ack_mode = 0;
        chk("t3_out_count", pops, FFT);
        chk("t3_sym_done", sd_cnt, 1);

        // Downstream stalled: prefix accepted, first body sample held, next one blocked
        clear_stats();
        ack_mode = 2;
        @(posedge clk); #1;
        send_range(1, CP + 1);
        in_if.dat = CP + 2;
        repeat (4) begin
            @(negedge clk);
            chk("t4_stall_ack_o", in_if.ack, 0);
            chk("t4_stall_stb_o", out_if.stb, 1);
            chk("t4_stall_dat_o", out_if.dat, CP + 1);
            @(posedge clk); #1;
        end
        ack_mode = 0;
        send_range(CP + 2, SYM);
        drain();
        chk("t4_out_count", pops, FFT);
        chk("t4_sym_done", sd_cnt, 1);

        // Reset mid-symbol after sample 100
        clear_stats();
        send_range(1, 100);
        rst = 1'b1;
        in_if.dat = 101;
        @(negedge clk);
        chk("t5_ack_in_rst", in_if.ack, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        pos = 0;
        in_if.cyc = 1'b0; in_if.stb = 1'b0; in_if.we = 1'b0;
        @(negedge clk);
        chk("t5_stb_o_zero", out_if.stb, 0);
        chk("t5_cyc_o_zero", out_if.cyc, 0);
        chk("t5_dat_o_zero", out_if.dat, 0);
        chk("t5_sym_done_zero", sym_done, 0);
        @(posedge clk); #1;
        clear_stats();
        send_range(1, SYM);
        drain();
        chk("t5_out_count", pops, FFT);
        chk("t5_sym_done", sd_cnt, 1);

        // Abort after sample 150, then a fresh symbol
        clear_stats();
        send_range(1, 150);
        idle(1);
        pos = 0;
        idle(2);
        @(negedge clk);
        chk("t6_cyc_o_after_abort", out_if.cyc, 0);
        chk("t6_abort_delivered", q.size(), 0);
        chk("t6_abort_no_sym_done", sd_cnt, 0);
        @(posedge clk); #1;
        send_range(1, SYM);
        drain();
        chk("t6_out_count", pops, (150 - CP) + FFT);
        chk("t6_sym_done", sd_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_cp_remove.md
Name: rx_cp_remove

Overview:
- Receive-side counterpart of the transmit cyclic-prefix inserter.
- Accepts a continuous stream of time-domain OFDM samples, one symbol = CP_LEN prefix samples followed by FFT_LEN body samples.
- Discards each prefix and forwards only the FFT_LEN body samples to the downstream FFT demodulator.
- Slave-side input and master-side output use the team's CYC/STB/WE/ACK streaming handshake.

Parameters:
- DAT_W, 32, sample width (16-bit I in [31:16], 16-bit Q in [15:0]); data passed unmodified.
- CP_LEN, 32, prefix samples dropped per symbol (1..FFT_LEN).
- FFT_LEN, 256, body samples forwarded per symbol.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- dat_i  in  DAT_W  input sample.
- we_i  in  1  write qualifier; must be 1 for a valid transfer.
- stb_i  in  1  input strobe, sample valid.
- cyc_i  in  1  input cycle, frame in progress.
- ack_o  out  1  input accept.
- dat_o  out  DAT_W  output sample.
- we_o  out  1  output write qualifier, equal to stb_o.
- stb_o  out  1  output sample valid.
- cyc_o  out  1  output cycle, high while a symbol body is being delivered.
- ack_i  in  1  downstream accept.
- sym_done  out  1  one-cycle pulse when the last body sample of a symbol is handshaken out.

Behaviour:
- Reset (rst=1 at clk edge):
  - ack_o=0, stb_o=0, we_o=0, cyc_o=0, sym_done=0, dat_o=0.
  - Sample counter cnt=0; last-flag cleared.
  - Any buffered sample is discarded. Reset mid-symbol restarts at prefix position 0.
- Input transfer: in_xfer = cyc_i & stb_i & we_i & ack_o.
- Output transfer: out_xfer = stb_o & ack_i.
- cnt runs 0..CP_LEN+FFT_LEN-1 and increments on each in_xfer. It wraps to 0 after CP_LEN+FFT_LEN-1, so back-to-back symbols need no gap.
- ack_o is combinational and low while rst is high:
  - DROP phase (cnt < CP_LEN): ack_o = cyc_i & stb_i & we_i. Prefix samples are always accepted and discarded; output registers untouched.
  - PASS phase (cnt >= CP_LEN): ack_o = cyc_i & stb_i & we_i & (~stb_o | ack_i). Output register is a one-deep pipeline; a new sample loads in the same cycle the held one leaves.
- Output register:
  - On a PASS-phase in_xfer: dat_o <= dat_i, stb_o <= 1, last <= (cnt == CP_LEN+FFT_LEN-1).
  - Else if out_xfer: stb_o <= 0.
  - dat_o holds its value while stb_o=1 and ack_i=0.
- Latency: one clock from accepted input to stb_o. Full throughput of 1 sample/clk in PASS phase when ack_i is held at 1.
- cyc_o: set together with stb_o on the first body sample (cnt == CP_LEN); cleared on the out_xfer of the sample with last=1.
- sym_done: pulses 1 in the cycle after the out_xfer of a last=1 sample.
- Abort: cyc_i=0 for a cycle while cnt != 0 resets cnt to 0 with no other effect. An already-registered output sample is still delivered; cyc_o stays high until it is acked, then drops with no sym_done pulse.
- Samples with we_i=0 are never accepted; ack_o stays 0.
- Simultaneous load and drain in PASS phase (stb_o=1, ack_i=1, in_xfer): stb_o stays 1 and dat_o takes the new sample. No bubble, no loss.
- No arithmetic on data. cnt width is clog2(CP_LEN+FFT_LEN).

Test Plan:
- Defaults, ack_i=1, one symbol of samples 1..288 sent one per clock with cyc/stb/we=1 → dat_o outputs exactly 33..288 in order on consecutive clocks. stb_o first rises one clock after sample 33 is accepted. cyc_o is high for 256 cycles. One sym_done pulse. Samples 1..32 never appear.
- Three back-to-back symbols (samples 1..864, no gap) → outputs 33..288, 321..576, 609..864 (768 total), three sym_done pulses, cnt=0 at end.
- ack_i toggled 1/0 every clock during PASS phase → ack_o stalls matching the pattern. No duplicated or dropped body samples: output count 256, data 33..288 intact.
- ack_i=0 for the whole symbol → all 32 prefix samples accepted. Sample 33 is registered, and ack_o stays 0 with dat_i=34 pending. After ack_i=1, output resumes 33,34,… with no loss.
- rst pulsed for one cycle after sample 100 of a symbol → all outputs 0 the next cycle. The following stream 1..288 yields 33..288 exactly.
- cyc_i dropped after sample 150, then a new symbol 1..288 → sample 150 (last registered body sample) is delivered, then no sym_done for the aborted symbol. The new symbol yields 33..288 with one sym_done.
